// File: rtl/input_fifo_if.sv
// Handshake bundle between a channel source/arbiter slot and one input_fifo instance.
interface input_fifo_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic [1:0]       sel;
    logic             rd_en;
    logic             err_clr;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, sel, rd_en, err_clr,
        input  dout, dout_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, sel, rd_en, err_clr,
        output dout, dout_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/input_fifo.sv
// Per-port router input buffer with registered read data and overflow/underflow reporting.
// Define INPUT_FIFO_STICKY_ERR_EN for sticky error flags cleared by err_clr.
module input_fifo #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned PORT_ID  = 0
) (
    input logic         clk,
    input logic         rst_n,
    input_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             overflow_q, underflow_q;

    logic rd_req, full, empty, almost_full;
    logic wr_acc, rd_acc, ovf_evt, udf_evt, ovf_d, udf_d;

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        empty       = (count_q == '0);
        almost_full = (count_q >= CW'(AF_LEVEL));
        rd_req      = bus.rd_en && (bus.sel == 2'(PORT_ID));
        rd_acc      = rd_req && !empty;
        // A pop frees the slot on the same edge, so a push into a full buffer is still taken.
        wr_acc      = bus.wr_en && (!full || rd_req);
        ovf_evt     = bus.wr_en && full && !rd_req;
        udf_evt     = rd_req && empty;
`ifdef INPUT_FIFO_STICKY_ERR_EN
        ovf_d       = ovf_evt || (overflow_q && !bus.err_clr);
        udf_d       = udf_evt || (underflow_q && !bus.err_clr);
`else
        ovf_d       = ovf_evt;
        udf_d       = udf_evt;
`endif
    end

`ifndef INPUT_FIFO_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
`endif

    // Storage is deliberately not reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                dout_q   <= mem_q[rd_ptr_q];
            end
            dout_valid_q <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overflow_q  <= ovf_d;
            underflow_q <= udf_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = almost_full;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: doc/input_fifo.md
# input_fifo

Per-port input buffer for the router, one instance for each of the four input channels. Each instance stores 4-bit symbols written by the channel's source and presents them to the round-robin output arbiter on its `fifoN_in` input. The arbiter reads the instance when its `sel` equals the instance's `PORT_ID`. The buffer provides full/empty/almost-full status, registered read data and overflow/underflow error reporting.

## Interface
- `WIDTH`, 4: symbol width in bits.
- `DEPTH`, 8: number of entries; must be a power of 2, at least 2.
- `AF_LEVEL`, 6: `almost_full` asserts when occupancy ≥ `AF_LEVEL`; range 1..`DEPTH`.
- `PORT_ID`, 0: arbiter slot number (0..3) served by this instance.

- `clk`  in  1  single clock; everything updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request.
- `din`  in  `WIDTH`  write data.
- `sel`  in  2  arbiter slot pointer. A read request is `sel == PORT_ID`.
- `rd_en`  in  1  read qualifier. The effective read is `rd_en && sel == PORT_ID`.
- `err_clr`  in  1  clears the sticky error flags; only meaningful with the macro defined.
- `dout`  out  `WIDTH`  registered read data; feeds the arbiter's `fifoN_in`.
- `dout_valid`  out  1  `dout` was loaded by a read on the previous edge.
- `full`  out  1  occupancy == `DEPTH`.
- `empty`  out  1  occupancy == 0.
- `almost_full`  out  1  occupancy ≥ `AF_LEVEL`.
- `count`  out  log2(`DEPTH`)+1  current occupancy.
- `overflow`  out  1  a write was attempted while the buffer was full.
- `underflow`  out  1  a read was attempted while the buffer was empty.

## Operation
- Storage: `DEPTH`×`WIDTH` register array.
  - Write and read pointers are log2(`DEPTH`) bits wide and wrap modulo `DEPTH`.
  - Occupancy is kept in `count`. The status flags `full`, `empty` and `almost_full` are decoded combinationally from `count`.
- Accepted write: `wr_en && !full`, or `wr_en && full && rd` (see simultaneous events).
  - Stores `din` at the write pointer, then increments the pointer.
- Accepted read: `rd && !empty`.
  - Loads the word at the read pointer into `dout`, increments the read pointer, and sets `dout_valid` to 1 on that edge.
  - On any edge without an accepted read, `dout` holds its value and `dout_valid` goes to 0.
- Count update: +1 on a write only, −1 on a read only, unchanged when both or neither are accepted.
- Simultaneous events:
  - Push and pop while full: both accepted, `count` stays at `DEPTH`, no overflow.
  - Push and pop while empty: the push is accepted, the pop is rejected, `underflow` is raised, and `count` becomes 1.
  - Otherwise: both accepted, `count` unchanged.
- Rejected write (full, no read): data is dropped, `overflow` is raised, and the pointers and count are unchanged.
- Rejected read (empty): `dout` is unchanged, `dout_valid` is 0, `underflow` is raised.
- Reset is asserted asynchronously and takes effect at any point, including mid-transfer. It clears the pointers and `count`, so buffered data is discarded.

## Timing
- Values on reset: `dout`=0, `dout_valid`=0, `count`=0, `empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0.
- Storage array contents are not reset.
- Write-to-read latency: a word written at edge N can be read at edge N+1 at the earliest, and appears on `dout` after edge N+1.
- Read latency: one cycle from the edge on which the read is accepted to `dout`.
- Status flags change on the same edge as `count`; there is no lookahead.

## Configuration
- `INPUT_FIFO_STICKY_ERR_EN` defined:
  - `overflow` and `underflow` are sticky. Each sets on its error event and holds until an edge where `err_clr`=1 and no new event of that type occurs.
  - If a new event coincides with `err_clr`, set wins.
- `INPUT_FIFO_STICKY_ERR_EN` undefined:
  - `overflow` and `underflow` are registered single-cycle pulses, high only in the cycle after the error event.
  - `err_clr` is ignored.

## Test plan
- Reset then single write and read (`PORT_ID`=0): write 0xA, then one edge later set `sel`=0, `rd_en`=1.
  - `dout`=0xA and `dout_valid`=1 for one cycle.
  - `count` goes 0→1→0; `empty` ends at 1.
- Fill to full: write 0x1..0x8 into `DEPTH`=8.
  - `almost_full` asserts after the 6th write; `full` asserts after the 8th.
  - A 9th write (0x9) raises `overflow`; reading back returns 0x1..0x8 in order.
- Slot mismatch: buffer holds 3 words, `rd_en`=1, `sel` cycles 1→2→3→0 with `PORT_ID`=0.
  - Exactly one read, on `sel`=0; `count` goes 3→2.
- Push and pop at boundaries:
  - Full with simultaneous write and read: `count` stays 8, no overflow.
  - Empty with simultaneous write and read: `count`=1, `underflow` raised, `dout_valid`=0.
- Wrap-around: 20 writes interleaved with reads, occupancy kept between 1 and 3.
  - Data returns in order across pointer wraps.
- Reset mid-operation: assert `rst_n`=0 between edges with `count`=5.
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - After release, a read returns nothing until a new write.
  - With the macro defined, an `overflow` flag raised before the reset is cleared by it; with the macro undefined, the flag is a single-cycle pulse.
